// File: rtl/pi_pkg.sv
// Shared constants, FSM encoding and sign-magnitude helpers for the PI sweep scheduler.
package pi_pkg;

  localparam int unsigned N_WIDTH   = 17;
  localparam int unsigned Q_WIDTH   = 8;
  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned ACC_Q     = 15;
  localparam int unsigned SAT_HI    = 250;
  localparam int unsigned SAT_LO    = 5;

  localparam logic [N_WIDTH-1:0] K_P_DEFAULT = 17'h00014;
  localparam logic [N_WIDTH-1:0] K_I_DEFAULT = 17'h00014;

  typedef enum logic [2:0] {
    StIdle, StLoad, StMulP, StMulI, StAcc, StSat, StWrite, StDone
  } pi_state_e;

  typedef logic [N_WIDTH-1:0]   sm_word_t;
  typedef logic [ACC_WIDTH-1:0] sm_acc_t;

  // a - b as sign-magnitude; the sign is set only when b > a, so zero is always +0.
  function automatic sm_word_t sm_diff(input logic [N_WIDTH-2:0] a, input logic [N_WIDTH-2:0] b);
    return (b > a) ? {1'b1, b - a} : {1'b0, a - b};
  endfunction

  // Q8 word -> Q15 accumulator word, magnitude left-aligned to the new binary point.
  function automatic sm_acc_t sm_widen(input sm_word_t w);
    return {w[N_WIDTH-1], {(ACC_WIDTH - N_WIDTH - (ACC_Q - Q_WIDTH)){1'b0}},
            w[N_WIDTH-2:0], {(ACC_Q - Q_WIDTH){1'b0}}};
  endfunction

endpackage

// File: rtl/pi_state_bank.sv
// Per-channel PI history (e_k1, u_k1): one combinational read port, one write port.
module pi_state_bank
  import pi_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned ChW = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [ChW-1:0] rd_ch_i,
  output sm_word_t       e_k1_o,
  output sm_word_t       u_k1_o,
  input  logic           we_i,
  input  logic [ChW-1:0] wr_ch_i,
  input  sm_word_t       e_i,
  input  sm_word_t       u_i
);
  sm_word_t e_q [NCH];
  sm_word_t u_q [NCH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < int'(NCH); c++) begin
        e_q[c] <= '0;
        u_q[c] <= '0;
      end
    end else if (we_i) begin
      e_q[wr_ch_i] <= e_i;
      u_q[wr_ch_i] <= u_i;
    end
  end

  assign e_k1_o = e_q[rd_ch_i];
  assign u_k1_o = u_q[rd_ch_i];

endmodule

// File: rtl/qadd.sv
// Sign-magnitude adder; the magnitude saturates on carry-out and a zero result is +0.
module qadd #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);
  logic [N-1:0] wide;
  logic [N-2:0] mag;
  logic         sign;

  always_comb begin
    wide = '0;
    sign = a_i[N-1];
    if (a_i[N-1] == b_i[N-1]) begin
      wide = {1'b0, a_i[N-2:0]} + {1'b0, b_i[N-2:0]};
    end else if (a_i[N-2:0] >= b_i[N-2:0]) begin
      wide = {1'b0, a_i[N-2:0] - b_i[N-2:0]};
    end else begin
      wide = {1'b0, b_i[N-2:0] - a_i[N-2:0]};
      sign = b_i[N-1];
    end
    mag   = wide[N-1] ? '1 : wide[N-2:0];
    sum_o = {sign && (mag != '0), mag};
  end

endmodule

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier with Q fractional bits; saturates the magnitude.
module qmult #(
  parameter int unsigned N = 17,
  parameter int unsigned Q = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o
);
  localparam int unsigned MW = N - 1;

  logic [2*MW-1:0] prod;
  logic [2*MW-1:0] scaled;
  logic [MW-1:0]   mag;

  always_comb begin
    prod     = {{MW{1'b0}}, a_i[MW-1:0]} * {{MW{1'b0}}, b_i[MW-1:0]};
    scaled   = prod >> Q;
    mag      = (|scaled[2*MW-1:MW]) ? '1 : scaled[MW-1:0];
    result_o = {(a_i[N-1] ^ b_i[N-1]) && (mag != '0), mag};
  end

endmodule

// File: rtl/pi_sweep_scheduler.sv
// Time-multiplexed PI controller: one shared qmult swept over NCH motor channels per tick.
module pi_sweep_scheduler
  import pi_pkg::*;
#(
  parameter int unsigned        NCH = 4,
  parameter logic [N_WIDTH-1:0] K_P = K_P_DEFAULT,
  parameter logic [N_WIDTH-1:0] K_I = K_I_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       sample_tick_i,
  input  logic [NCH-1:0]             ch_enable_i,
  input  logic [NCH*(N_WIDTH-1)-1:0] setpoint_bus_i,
  input  logic [NCH*(N_WIDTH-1)-1:0] measured_bus_i,
  input  logic                       clear_overrun_i,
  output logic [NCH*8-1:0]           pwm_bus_o,
  output logic                       busy_o,
  output logic                       sweep_done_o,
  output logic                       overrun_o
);
  localparam int unsigned MagW = N_WIDTH - 1;
  localparam int unsigned ChW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IntW = ACC_WIDTH - 1 - ACC_Q;

  pi_state_e state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;

  logic                   en_q, overrun_q;
  sm_word_t               e_q, p_q, i_q, u_sat_q, u_sat_d;
  sm_acc_t                u_q, sum_pu, sum_acc;
  logic [7:0]             pwm_val_q, pwm_val_d;
  logic [NCH-1:0][7:0]    pwm_q;
  logic [MagW-1:0]        sp, meas;
  logic [IntW-1:0]        int_part;
  logic [MagW-1:0]        u_mag_q8;
  sm_word_t               mul_a, mul_b, prod, e_k1, u_k1;

  assign busy_o       = (state_q != StIdle);
  assign sweep_done_o = (state_q == StDone);
  assign overrun_o    = overrun_q;
  assign pwm_bus_o    = pwm_q;

  assign sp   = setpoint_bus_i[ch_q*MagW +: MagW];
  assign meas = measured_bus_i[ch_q*MagW +: MagW];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        if (sample_tick_i) begin
          state_d = StLoad;
          ch_d    = '0;
        end
      end
      StLoad:  state_d = StMulP;
      StMulP:  state_d = StMulI;
      StMulI:  state_d = StAcc;
      StAcc:   state_d = StSat;
      StSat:   state_d = StWrite;
      StWrite: begin
        if (ch_q == ChW'(NCH - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StLoad;
          ch_d    = ch_q + ChW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The single multiplier serves K_P*e in MUL_P and K_I*e_k1 in MUL_I.
  assign mul_a = (state_q == StMulI) ? K_I : K_P;
  assign mul_b = (state_q == StMulI) ? e_k1 : e_q;

  qmult #(.N(N_WIDTH), .Q(Q_WIDTH)) u_qmult (
    .a_i      (mul_a),
    .b_i      (mul_b),
    .result_o (prod)
  );

  qadd #(.N(ACC_WIDTH)) u_qadd_pu (
    .a_i   (sm_widen(u_k1)),
    .b_i   (sm_widen(p_q)),
    .sum_o (sum_pu)
  );

  qadd #(.N(ACC_WIDTH)) u_qadd_i (
    .a_i   (sum_pu),
    .b_i   (sm_widen(i_q)),
    .sum_o (sum_acc)
  );

  pi_state_bank #(.NCH(NCH), .ChW(ChW)) u_bank (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rd_ch_i (ch_q),
    .e_k1_o  (e_k1),
    .u_k1_o  (u_k1),
    .we_i    (state_q == StWrite),
    .wr_ch_i (ch_q),
    .e_i     (en_q ? e_q : '0),
    .u_i     (en_q ? u_sat_q : '0)
  );

  // Clamping the stored u to SAT_HI.0 / +0 is the anti-windup.
  always_comb begin
    int_part  = IntW'(u_q[ACC_WIDTH-2:0] >> ACC_Q);
    u_mag_q8  = MagW'(u_q[ACC_WIDTH-2:0] >> (ACC_Q - Q_WIDTH));
    pwm_val_d = int_part[7:0];
    u_sat_d   = {u_q[ACC_WIDTH-1], u_mag_q8};
    if (u_q[ACC_WIDTH-1] || (int_part <= IntW'(SAT_LO))) begin
      pwm_val_d = 8'd0;
      u_sat_d   = '0;
    end else if (int_part >= IntW'(SAT_HI)) begin
      pwm_val_d = 8'hFF;
      u_sat_d   = {1'b0, MagW'(SAT_HI << Q_WIDTH)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      en_q      <= 1'b0;
      e_q       <= '0;
      p_q       <= '0;
      i_q       <= '0;
      u_q       <= '0;
      pwm_val_q <= '0;
      u_sat_q   <= '0;
      pwm_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (state_q == StLoad) begin
        en_q <= ch_enable_i[ch_q];
        e_q  <= sm_diff(sp, meas);
      end
      if (state_q == StMulP) p_q <= prod;
      if (state_q == StMulI) i_q <= prod;
      if (state_q == StAcc)  u_q <= sum_acc;
      if (state_q == StSat) begin
        pwm_val_q <= pwm_val_d;
        u_sat_q   <= u_sat_d;
      end
      if (state_q == StWrite) pwm_q[ch_q] <= en_q ? pwm_val_q : 8'd0;
      if (sample_tick_i && busy_o) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule
